// File: rtl/pc_pkg.sv
// Shared types, default vectors and the alignment helper for the PC unit.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALTED
  } pc_state_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

  // Only the two low address bits matter because the step is 2 or 4 bytes.
  function automatic logic is_aligned(input logic [1:0] addr, input int unsigned incr);
    if (incr == 2)
      return ~addr[0];
    else
      return (addr == 2'b00);
  endfunction

endpackage

// File: rtl/pc_unit_retire_counter.sv
// Wrapping retired-instruction counter with synchronous clear.
module retire_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  // Count enabled cycles; clear wins over enable.
  always_ff @(posedge clk) begin
    if (clear)
      count <= '0;
    else if (enable)
      count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: fetch address, redirect/trap handling, halt/resume
// and retired-instruction count.
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned       XLEN         = 32,
  parameter int unsigned       INCR         = 4,
  parameter logic [XLEN-1:0]   RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter logic [XLEN-1:0]   TRAP_VECTOR  = XLEN'(DEFAULT_TRAP_VECTOR),
  parameter int unsigned       CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_target,
  input  logic              trap_req,
  input  logic              halt_req,
  input  logic              resume,
  output logic [XLEN-1:0]   pc,
  output logic [XLEN-1:0]   pc_plus_incr,
  output logic              fetch_valid,
  output logic [XLEN-1:0]   epc,
  output logic              fault,
  output logic [XLEN-1:0]   fault_addr,
  output logic [CNT_W-1:0]  retired,
  output logic              halted
);

  localparam logic [XLEN-1:0] INCR_STEP = XLEN'(INCR);

  pc_state_t       state, state_next;
  logic [XLEN-1:0] pc_next, epc_next, fault_addr_next;
  logic            fault_next;
  logic            step_en;
  logic            target_ok;

  assign step_en      = advance && !stall;
  assign target_ok    = is_aligned(redirect_target[1:0], INCR);
  assign pc_plus_incr = pc + INCR_STEP;

  // State register.
  always_ff @(posedge clk) begin
    if (rst)
      state <= BOOT;
    else
      state <= state_next;
  end

  // Next-state logic and state-derived outputs.
  always_comb begin
    state_next  = state;
    fetch_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        fetch_valid = 1'b1;
        if (halt_req)
          state_next = HALTED;
      end
      HALTED: begin
        halted = 1'b1;
        if (resume)
          state_next = RUN;
      end
      default: state_next = BOOT;
    endcase
  end

  // PC update selection in RUN: trap, aligned redirect, misaligned fault, step, hold.
  always_comb begin
    pc_next         = pc;
    epc_next        = epc;
    fault_addr_next = fault_addr;
    fault_next      = 1'b0;
    if (state == RUN) begin
      if (trap_req) begin
        pc_next  = TRAP_VECTOR;
        epc_next = pc;
      end else if (redirect_valid && target_ok) begin
        pc_next = redirect_target;
      end else if (redirect_valid) begin
        pc_next         = TRAP_VECTOR;
        epc_next        = pc;
        fault_addr_next = redirect_target;
        fault_next      = 1'b1;
      end else if (step_en) begin
        pc_next = pc_plus_incr;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_VECTOR;
      epc        <= '0;
      fault_addr <= '0;
      fault      <= 1'b0;
    end else begin
      pc         <= pc_next;
      epc        <= epc_next;
      fault_addr <= fault_addr_next;
      fault      <= fault_next;
    end
  end

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire (
    .clk    (clk),
    .clear  (rst),
    .enable ((state == RUN) && step_en),
    .count  (retired)
  );

endmodule

// File: tb/tb_pc_unit.sv
// Directed testbench for pc_unit with a cycle-level reference model.
module tb_pc_unit;

  localparam logic [31:0] RV = 32'h0000_0000;
  localparam logic [31:0] TV = 32'h0000_0100;
  localparam int M_BOOT = 0, M_RUN = 1, M_HALT = 2;

  logic        clk = 1'b0;
  logic        rst, advance, stall, redirect_valid, trap_req, halt_req, resume;
  logic [31:0] redirect_target;
  logic [31:0] pc, pc_plus_incr, epc, fault_addr, retired;
  logic        fetch_valid, fault, halted;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc, m_epc, m_faddr, m_ret;
  logic        m_fault;
  int          m_state;
  bit          m_valid = 1'b0;

  pc_unit #(
    .XLEN         (32),
    .INCR         (4),
    .RESET_VECTOR (RV),
    .TRAP_VECTOR  (TV),
    .CNT_W        (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .advance         (advance),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .trap_req        (trap_req),
    .halt_req        (halt_req),
    .resume          (resume),
    .pc              (pc),
    .pc_plus_incr    (pc_plus_incr),
    .fetch_valid     (fetch_valid),
    .epc             (epc),
    .fault           (fault),
    .fault_addr      (fault_addr),
    .retired         (retired),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model, and let the DUT clock once.
  task automatic step(input logic r, input logic a, input logic s, input logic rv,
                      input logic [31:0] t, input logic tr, input logic h, input logic res);
    logic [31:0] n_pc, n_epc, n_faddr, n_ret;
    logic        n_fault;
    int          n_state;
    rst = r; advance = a; stall = s; redirect_valid = rv; redirect_target = t;
    trap_req = tr; halt_req = h; resume = res;
    n_pc = m_pc; n_epc = m_epc; n_faddr = m_faddr; n_ret = m_ret;
    n_fault = 1'b0; n_state = m_state;
    if (r) begin
      n_pc = RV; n_epc = 0; n_faddr = 0; n_ret = 0; n_state = M_BOOT;
    end else if (m_state == M_BOOT) begin
      n_state = M_RUN;
    end else if (m_state == M_RUN) begin
      if (a && !s) n_ret = m_ret + 1;
      if (tr) begin
        n_pc = TV; n_epc = m_pc;
      end else if (rv && (t % 4 == 0)) begin
        n_pc = t;
      end else if (rv) begin
        n_pc = TV; n_epc = m_pc; n_faddr = t; n_fault = 1'b1;
      end else if (a && !s) begin
        n_pc = m_pc + 32'd4;
      end
      if (h) n_state = M_HALT;
    end else begin
      if (res) n_state = M_RUN;
    end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_epc = n_epc; m_faddr = n_faddr; m_ret = n_ret;
    m_fault = n_fault; m_state = n_state;
    if (r) m_valid = 1'b1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 32'h0, 0, 0, 0);
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("pc", pc, m_pc);
      check("pc_plus_incr", pc_plus_incr, m_pc + 32'd4);
      check("epc", epc, m_epc);
      check("fault", {31'b0, fault}, {31'b0, m_fault});
      check("fault_addr", fault_addr, m_faddr);
      check("retired", retired, m_ret);
      check("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_state == M_RUN});
      check("halted", {31'b0, halted}, {31'b0, m_state == M_HALT});
    end
  end

  initial begin
    rst = 1'b1; advance = 0; stall = 0; redirect_valid = 0; redirect_target = 0;
    trap_req = 0; halt_req = 0; resume = 0;

    // Reset state
    step(1, 0, 0, 0, 32'h0, 0, 0, 0);
    check("rst_pc", pc, 32'h0);
    check("rst_fv", {31'b0, fetch_valid}, 32'h0);
    check("rst_ret", retired, 32'h0);
    check("rst_fault", {31'b0, fault}, 32'h0);

    // BOOT ignores advance and halt_req
    step(0, 1, 0, 0, 32'h0, 0, 1, 0);
    check("boot_pc", pc, 32'h0);
    check("boot_halt_ignored", {31'b0, halted}, 32'h0);
    check("boot_to_run_fv", {31'b0, fetch_valid}, 32'h1);
    step(0, 1, 0, 0, 32'h0, 0, 0, 0);
    check("adv_pc4", pc, 32'h4);
    step(0, 1, 0, 0, 32'h0, 0, 0, 0);
    check("adv_pc8", pc, 32'h8);
    check("adv_ret2", retired, 32'h2);
    step(0, 1, 0, 0, 32'h0, 0, 0, 0);
    step(0, 1, 0, 0, 32'h0, 0, 0, 0);
    check("adv_pc10", pc, 32'h10);

    // Stall blocks advance only
    step(0, 1, 1, 0, 32'h0, 0, 0, 0);
    check("stall_pc", pc, 32'h10);
    check("stall_ret", retired, 32'h4);
    step(0, 1, 1, 1, 32'h40, 0, 0, 0);
    check("stall_redir_pc", pc, 32'h40);
    check("stall_redir_link", pc_plus_incr, 32'h44);

    // Trap beats redirect
    step(0, 0, 0, 1, 32'h20, 0, 0, 0);
    step(0, 0, 0, 1, 32'h80, 1, 0, 0);
    check("trap_pc", pc, 32'h100);
    check("trap_epc", epc, 32'h20);
    check("trap_fault", {31'b0, fault}, 32'h0);

    // Redirect with advance still retires
    step(0, 1, 0, 1, 32'h30, 0, 0, 0);
    check("redir_adv_ret", retired, 32'h5);

    // Misaligned redirect faults for one cycle
    step(0, 0, 0, 1, 32'h42, 0, 0, 0);
    check("mis_pc", pc, 32'h100);
    check("mis_epc", epc, 32'h30);
    check("mis_faddr", fault_addr, 32'h42);
    check("mis_fault", {31'b0, fault}, 32'h1);
    idle();
    check("mis_fault_drop", {31'b0, fault}, 32'h0);

    // Halt with a concurrent step, then ignore inputs while halted
    step(0, 0, 0, 1, 32'h8, 0, 0, 0);
    step(0, 1, 0, 0, 32'h0, 0, 1, 0);
    check("halt_pc", pc, 32'hC);
    check("halt_flag", {31'b0, halted}, 32'h1);
    check("halt_fv", {31'b0, fetch_valid}, 32'h0);
    for (int i = 0; i < 5; i++)
      step(0, 1, 0, (i == 3), 32'h42, (i == 2), 0, 0);
    check("halted_pc", pc, 32'hC);
    check("halted_ret", retired, 32'h6);
    check("halted_epc", epc, 32'h30);
    step(0, 0, 0, 0, 32'h0, 0, 0, 1);
    check("resume_pc", pc, 32'hC);
    check("resume_fv", {31'b0, fetch_valid}, 32'h1);

    // Wrap at the top of the address space
    step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
    check("wrap_link", pc_plus_incr, 32'h0);
    step(0, 1, 0, 0, 32'h0, 0, 0, 0);
    check("wrap_pc", pc, 32'h0);
    check("wrap_ret", retired, 32'h7);

    // Back-to-back misaligned redirects keep fault high, including under stall
    step(0, 1, 1, 1, 32'h6, 0, 0, 0);
    step(0, 0, 0, 1, 32'h2, 0, 0, 0);
    check("mis2_fault", {31'b0, fault}, 32'h1);
    check("mis2_faddr", fault_addr, 32'h2);
    check("mis2_epc", epc, 32'h100);
    idle();

    // Reset overrides everything while halted
    step(0, 0, 0, 0, 32'h0, 0, 1, 0);
    check("halt2_flag", {31'b0, halted}, 32'h1);
    step(1, 1, 0, 1, 32'h40, 1, 0, 1);
    check("rst2_pc", pc, RV);
    check("rst2_halted", {31'b0, halted}, 32'h0);
    check("rst2_fv", {31'b0, fetch_valid}, 32'h0);
    check("rst2_ret", retired, 32'h0);
    check("rst2_faddr", fault_addr, 32'h0);
    idle();
    idle();
    check("rst2_run", {31'b0, fetch_valid}, 32'h1);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
